mem_trace_monitor: RTL



---
 rtl/mem_trace_monitor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_trace_monitor.sv
// Board debug monitor: snapshots PC/IR per CPU step, keeps a ring buffer
// of recent data-memory stores, and shows either on four hex displays.
module mem_trace_monitor #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [15:0]       pc,
  input  logic [15:0]       ir,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [15:0]       dmem_din,
  input  logic [1:0]        mode,
  input  logic              scroll_btn,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [9:0]        ledr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ONE = 1;
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] ZERO = 7'b1000000;

  logic [15:0]           pc_q;
  logic [15:0]           ir_q;
  logic [ADDR_W-1:0]     addr_mem [DEPTH];
  logic [15:0]           data_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] view;
  logic [DEPTH_LOG2-1:0] view_nx;
  logic [DEPTH_LOG2-1:0] sel;
  logic [3:0]            count;
  logic                  btn_q;
  logic                  ovf;
  logic                  hb;
  logic                  push;
  logic                  rise;
  logic                  full;
  logic                  dash;
  logic [15:0]           word;

  assign push = tick & dmem_we;
  assign rise = scroll_btn & ~btn_q;
  assign full = (count == FULL_CNT);
  assign sel  = wptr - ONE - view;
  assign dash = mode[1] & (count == 4'd0);

  // A push always snaps the view back to the newest entry.
  always_comb begin
    view_nx = view;
    if (push) begin
      view_nx = '0;
    end else if (rise) begin
      if (count == 4'd0)
        view_nx = '0;
      else if ((4'(view) + 4'd1) == count)
        view_nx = '0;
      else
        view_nx = view + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ir_q  <= '0;
      wptr  <= '0;
      count <= '0;
      view  <= '0;
      btn_q <= 1'b0;
      ovf   <= 1'b0;
      hb    <= 1'b0;
    end else begin
      btn_q <= scroll_btn;
      view  <= view_nx;
      if (tick) begin
        pc_q <= pc;
        ir_q <= ir;
        hb   <= ~hb;
      end
      if (push) begin
        wptr <= wptr + ONE;
        if (full)
          ovf <= 1'b1;
        else
          count <= count + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= dmem_addr;
      data_mem[wptr] <= dmem_din;
    end
  end

  always_comb begin
    word = '0;
    unique case (mode)
      2'd0: word = pc_q;
      2'd1: word = ir_q;
      2'd2: word = data_mem[sel];
      2'd3: word = 16'(addr_mem[sel]);
    endcase
  end

  function automatic logic [6:0] hexdec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hex0 <= ZERO;
      hex1 <= ZERO;
      hex2 <= ZERO;
      hex3 <= ZERO;
      ledr <= '0;
    end else begin
      hex0 <= dash ? DASH : hexdec(word[3:0]);
      hex1 <= dash ? DASH : hexdec(word[7:4]);
      hex2 <= dash ? DASH : hexdec(word[11:8]);
      hex3 <= dash ? DASH : hexdec(word[15:12]);
      ledr <= {hb, full, 3'(view), ovf, count};
    end
  end

endmodule
